// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-port memory bus arbiter with programmable wait states
// and error completion for accesses to unused chip-selects or writes to ROM.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  input  logic [1:0]            i_size0,
  input  logic [1:0]            i_size1,
  input  logic [1:0]            i_cs0,
  input  logic [1:0]            i_cs1,
  output logic                  o_gnt0,
  output logic                  o_gnt1,
  output logic                  o_done0,
  output logic                  o_done1,
  output logic                  o_err0,
  output logic                  o_err1,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [1:0]            o_mem_cs,
  output logic                  o_mem_write_en,
  output logic                  o_mem_read,
  output logic [1:0]            o_mem_size,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  logic [1:0]            r_state;
  logic                  r_last, r_owner, r_we, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [1:0]            r_size, r_cs;
  logic [3:0]            r_cnt;
  logic                  w_pick, w_we, w_illegal, w_access, w_done, w_busy;
  logic [1:0]            w_cs;
  // on a tie the port that did not own the bus last time wins
  assign w_pick    = (i_req0 & i_req1) ? ~r_last : i_req1;
  assign w_we      = w_pick ? i_we1 : i_we0;
  assign w_cs      = w_pick ? i_cs1 : i_cs0;
  assign w_illegal = (w_cs == 2'b00) | (w_we & (w_cs == 2'b10));
  assign w_access  = r_state == ACCESS;
  assign w_done    = r_state == DONE;
  assign w_busy    = r_state != IDLE;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_size  <= '0;
      r_cs    <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE && (i_req0 | i_req1)) begin
      r_owner <= w_pick;
      r_last  <= w_pick;
      r_we    <= w_we;
      r_cs    <= w_cs;
      r_addr  <= w_pick ? i_addr1 : i_addr0;
      r_wdata <= w_pick ? i_wdata1 : i_wdata0;
      r_size  <= w_pick ? i_size1 : i_size0;
      r_err   <= w_illegal;
      r_cnt   <= WS;
      r_state <= w_illegal ? DONE : ACCESS;
    end else if (w_access) begin
      r_cnt   <= (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
      r_rdata <= (r_cnt == 4'd0 && !r_we) ? i_mem_rdata : r_rdata;
      r_state <= (r_cnt == 4'd0) ? DONE : ACCESS;
    end else if (w_done) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end
  assign o_gnt0         = w_busy & ~r_owner;
  assign o_gnt1         = w_busy & r_owner;
  assign o_done0        = w_done & ~r_owner;
  assign o_done1        = w_done & r_owner;
  assign o_err0         = w_done & r_err & ~r_owner;
  assign o_err1         = w_done & r_err & r_owner;
  assign o_rdata        = r_rdata;
  // memory side stays idle outside ACCESS
  assign o_mem_address  = w_access ? r_addr : '0;
  assign o_mem_wdata    = w_access ? r_wdata : '0;
  assign o_mem_cs       = w_access ? r_cs : 2'b00;
  assign o_mem_size     = w_access ? r_size : 2'b00;
  assign o_mem_write_en = w_access & r_we;
  assign o_mem_read     = w_access & ~r_we;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: two arbiters (WAIT_STATES 1 and 0) share directed stimulus and are
// compared every cycle against a per-access schedule model, plus hand-computed expectations.
module tb_mem_bus_arbiter;
  logic        clk, rst_n, req0, req1, we0, we1;
  logic [31:0] addr0, addr1;
  logic [63:0] wdata0, wdata1, mem_rdata;
  logic [1:0]  size0, size1, cs0, cs1;
  logic [1:0]  gnt0, gnt1, done0, done1, err0, err1, mem_we, mem_rd;
  logic [63:0] rdata [2];
  logic [63:0] mem_wdata [2];
  logic [31:0] mem_addr [2];
  logic [1:0]  mem_cs [2];
  logic [1:0]  mem_size [2];
  int checks = 0, failures = 0;
  int ws [2] = '{1, 0};
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .WAIT_STATES(g == 0 ? 1 : 0)) dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
      .i_size0(size0), .i_size1(size1), .i_cs0(cs0), .i_cs1(cs1),
      .o_gnt0(gnt0[g]), .o_gnt1(gnt1[g]), .o_done0(done0[g]), .o_done1(done1[g]),
      .o_err0(err0[g]), .o_err1(err1[g]), .o_rdata(rdata[g]),
      .o_mem_address(mem_addr[g]), .o_mem_wdata(mem_wdata[g]), .o_mem_cs(mem_cs[g]),
      .o_mem_write_en(mem_we[g]), .o_mem_read(mem_rd[g]), .o_mem_size(mem_size[g]),
      .i_mem_rdata(mem_rdata));
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int d, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, d, a, e, $time);
    end
  endtask
  // model: an access granted at edge E occupies cycles k=1.. after E; ACCESS for k<=ws+1,
  // DONE at k=ws+2 (k=1 for an illegal access)
  bit          m_act [2], m_own [2], m_we [2], m_ill [2], m_last [2];
  int          m_k [2];
  logic [31:0] m_addr [2];
  logic [63:0] m_wd [2], m_rd [2];
  logic [1:0]  m_sz [2], m_cs [2];
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_act[d] = 0; m_last[d] = 1; m_rd[d] = '0; m_k[d] = 0;
      end else if (!m_act[d]) begin
        if (req0 || req1) begin
          bit p;
          p = (req0 && req1) ? !m_last[d] : req1;
          m_own[d] = p; m_last[d] = p;
          m_we[d] = p ? we1 : we0;
          m_cs[d] = p ? cs1 : cs0;
          m_addr[d] = p ? addr1 : addr0;
          m_wd[d] = p ? wdata1 : wdata0;
          m_sz[d] = p ? size1 : size0;
          m_ill[d] = (m_cs[d] == 2'b00) || (m_we[d] && m_cs[d] == 2'b10);
          m_act[d] = 1; m_k[d] = 1; m_rd[d] = '0;
        end
      end else begin
        if (!m_ill[d] && m_k[d] == ws[d] + 1) m_rd[d] = m_we[d] ? 64'd0 : mem_rdata;
        if (m_k[d] == (m_ill[d] ? 1 : ws[d] + 2)) begin
          m_act[d] = 0; m_rd[d] = '0;
        end else m_k[d]++;
      end
    end
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit acc, dn;
      acc = m_act[d] && !m_ill[d] && m_k[d] <= ws[d] + 1;
      dn  = m_act[d] && m_k[d] == (m_ill[d] ? 1 : ws[d] + 2);
      chk("gnt0", d, gnt0[d], m_act[d] && !m_own[d]);
      chk("gnt1", d, gnt1[d], m_act[d] && m_own[d]);
      chk("done0", d, done0[d], dn && !m_own[d]);
      chk("done1", d, done1[d], dn && m_own[d]);
      chk("err0", d, err0[d], dn && m_ill[d] && !m_own[d]);
      chk("err1", d, err1[d], dn && m_ill[d] && m_own[d]);
      chk("rdata", d, rdata[d], m_rd[d]);
      chk("mem_address", d, mem_addr[d], acc ? m_addr[d] : 32'd0);
      chk("mem_wdata", d, mem_wdata[d], acc ? m_wd[d] : 64'd0);
      chk("mem_cs", d, mem_cs[d], acc ? m_cs[d] : 2'b00);
      chk("mem_size", d, mem_size[d], acc ? m_sz[d] : 2'b00);
      chk("mem_write_en", d, mem_we[d], acc && m_we[d]);
      chk("mem_read", d, mem_rd[d], acc && !m_we[d]);
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_done(input int d, input int p, input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = p ? done1[d] : done0[d];
    end
    chk("wait_done", d, 64'(seen), 64'd1);
  endtask
  initial begin
    int order [4];
    int n, strobes;
    rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    size0 = '0; size1 = '0; cs0 = '0; cs1 = '0; mem_rdata = '0;
    idle(2);
    chk("rst_gnt0", 0, gnt0[0], 0);
    chk("rst_mem_cs", 0, mem_cs[0], 0);
    chk("rst_rdata", 0, rdata[0], 0);
    rst_n = 1;
    idle(1);
    // read with one wait state
    req0 = 1; we0 = 0; cs0 = 2'b01; addr0 = 32'h10; mem_rdata = 64'hDEADBEEF_00000001;
    @(negedge clk);
    chk("s1_read_c1", 0, mem_rd[0], 1);
    chk("s1_addr_c1", 0, mem_addr[0], 32'h10);
    @(negedge clk);
    chk("s1_read_c2", 0, mem_rd[0], 1);
    @(negedge clk);
    chk("s1_done0", 0, done0[0], 1);
    chk("s1_rdata", 0, rdata[0], 64'hDEADBEEF_00000001);
    chk("s1_err0", 0, err0[0], 0);
    chk("s1_read_off", 0, mem_rd[0], 0);
    req0 = 0;
    idle(4);
    // contention from reset: strict alternation starting at port 0
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; req0 = 1; req1 = 1; we1 = 0; cs1 = 2'b01;
    addr0 = 32'h100; addr1 = 32'h200;
    n = 0; strobes = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      strobes += int'(mem_rd[0]);
      if (done0[0] || done1[0]) begin
        order[n] = int'(done1[0]);
        n++;
      end
    end
    chk("s2_count", 0, 64'(n), 4);
    for (int i = 0; i < 4; i++) chk("s2_order", 0, 64'(order[i]), 64'(i % 2));
    chk("s2_strobes", 0, 64'(strobes), 8);
    req0 = 0; req1 = 0;
    idle(6);
    // write to ROM is rejected without a strobe
    req1 = 1; we1 = 1; cs1 = 2'b10; addr1 = 32'h300;
    @(negedge clk);
    chk("s3_done1", 0, done1[0], 1);
    chk("s3_err1", 0, err1[0], 1);
    chk("s3_mem_cs", 0, mem_cs[0], 0);
    chk("s3_we", 0, mem_we[0], 0);
    req1 = 0; we1 = 0;
    idle(4);
    // write with latched address
    req0 = 1; we0 = 1; cs0 = 2'b01; addr0 = 32'h20; wdata0 = 64'h55; size0 = 2'b11;
    @(negedge clk);
    chk("s4_we_c1", 0, mem_we[0], 1);
    chk("s4_addr_c1", 0, mem_addr[0], 32'h20);
    chk("s4_size", 0, mem_size[0], 2'b11);
    chk("s4_wdata", 0, mem_wdata[0], 64'h55);
    addr0 = 32'h99;
    @(negedge clk);
    chk("s4_we_c2", 0, mem_we[0], 1);
    chk("s4_addr_c2", 0, mem_addr[0], 32'h20);
    @(negedge clk);
    chk("s4_done0", 0, done0[0], 1);
    chk("s4_rdata", 0, rdata[0], 0);
    req0 = 0; we0 = 0;
    idle(4);
    // reset in the middle of an access
    req1 = 1; we1 = 0; cs1 = 2'b01; addr1 = 32'h400; mem_rdata = 64'hA5A5;
    @(negedge clk);
    chk("s5_gnt1", 0, gnt1[0], 1);
    chk("s5_read", 0, mem_rd[0], 1);
    #2 rst_n = 0;
    #1;
    chk("s5_rst_gnt1", 0, gnt1[0], 0);
    chk("s5_rst_read", 0, mem_rd[0], 0);
    chk("s5_rst_addr", 0, mem_addr[0], 0);
    req0 = 1; we0 = 0; cs0 = 2'b01; addr0 = 32'h500;
    @(negedge clk);
    chk("s5_no_done", 0, done1[0], 0);
    rst_n = 1;
    @(negedge clk);
    chk("s5_first_gnt0", 0, gnt0[0], 1);
    chk("s5_first_gnt1", 0, gnt1[0], 0);
    chk("s5_addr", 0, mem_addr[0], 32'h500);
    wait_done(0, 0, 10);
    req0 = 0;
    wait_done(0, 1, 10);
    req1 = 0;
    idle(4);
    // zero wait states, peripheral read; req dropped mid-access on the slower arbiter
    req1 = 1; we1 = 0; cs1 = 2'b11; addr1 = 32'h40; mem_rdata = 64'h1234;
    @(negedge clk);
    chk("s6_read", 1, mem_rd[1], 1);
    chk("s6_cs", 1, mem_cs[1], 2'b11);
    chk("s6_addr", 1, mem_addr[1], 32'h40);
    @(negedge clk);
    chk("s6_done1", 1, done1[1], 1);
    chk("s6_rdata", 1, rdata[1], 64'h1234);
    chk("s6_err1", 1, err1[1], 0);
    req1 = 0;
    @(negedge clk);
    chk("s6_late_done1", 0, done1[0], 1);
    chk("s6_late_rdata", 0, rdata[0], 64'h1234);
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
